// File: rtl/mm_pkg.sv
// Shared types and dimensions for the matrix-multiply job controller.
// The pipeline depth constants fix the mac_clr / C_wen alignment and the DRAIN length.
package mm_pkg;

    localparam int DIM       = 4;
    localparam int IDX_W     = $clog2(DIM);
    localparam int MAT_SIZE  = DIM * DIM;
    localparam int RD_LAT    = 1;
    localparam int MAC_LAT   = 1;
    localparam int DRAIN_CYC = RD_LAT + MAC_LAT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mm_loop_cnt.sv
// Nested i/j/k index counter: k innermost, then j, then i, each wrapping at DIM-1.
// clr has priority over en; all_last flags the final (DIM-1, DIM-1, DIM-1) point.
module mm_loop_cnt
    import mm_pkg::*;
#(
    parameter int DIM   = mm_pkg::DIM,
    parameter int IDX_W = $clog2(DIM)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [IDX_W-1:0] i,
    output logic [IDX_W-1:0] j,
    output logic [IDX_W-1:0] k,
    output logic             k_last,
    output logic             all_last
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIM - 1);

    logic [IDX_W-1:0] r_i;
    logic [IDX_W-1:0] r_j;
    logic [IDX_W-1:0] r_k;
    logic             w_j_last;
    logic             w_i_last;

    assign k_last   = (r_k == LAST);
    assign w_j_last = (r_j == LAST);
    assign w_i_last = (r_i == LAST);
    assign all_last = k_last && w_j_last && w_i_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (clr) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (en) begin
            if (k_last) begin
                r_k <= '0;
                if (w_j_last) begin
                    r_j <= '0;
                    r_i <= w_i_last ? '0 : r_i + 1'b1;
                end else begin
                    r_j <= r_j + 1'b1;
                end
            end else begin
                r_k <= r_k + 1'b1;
            end
        end
    end

    assign i = r_i;
    assign j = r_j;
    assign k = r_k;

endmodule

// File: rtl/mm_job_ctrl.sv
// Matrix-multiply job controller: sweeps the i/j/k loop nest and aligns mac_clr / C_wen
// to the 1-cycle RAM read and the registered MAC. All outputs come straight from flops.
//
// state | meaning
// IDLE  | waiting for start; host may own the memories
// RUN   | issuing one operand pair per cycle
// DRAIN | flushing the read and MAC stages
// DONE  | job complete, C holds the result
module mm_job_ctrl
    import mm_pkg::*;
#(
    parameter int DIM   = mm_pkg::DIM,
    parameter int IDX_W = $clog2(DIM),
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             load_mem,
    output logic             busy,
    output logic             done,
    output logic             abort,
    output logic             mac_clr,
    output logic             C_wen,
    output logic [IDX_W-1:0] Ai,
    output logic [IDX_W-1:0] Aj,
    output logic [IDX_W-1:0] Bi,
    output logic [IDX_W-1:0] Bj,
    output logic [IDX_W-1:0] Ci,
    output logic [IDX_W-1:0] Cj,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam logic [1:0] DRAIN_LOAD = 2'(DRAIN_CYC - 1);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [IDX_W-1:0] w_i;
    logic [IDX_W-1:0] w_j;
    logic [IDX_W-1:0] w_k;
    logic             w_k_last;
    logic             w_all_last;
    logic             w_cnt_en;
    logic             w_cnt_clr;
    logic             w_issue;
    logic             w_abort_req;
    logic             w_job_start;
    logic             w_active;

    logic [1:0]       r_drain;
    logic             r_busy;
    logic             r_done;
    logic             r_abort;
    logic             r_mac_clr;
    logic             r_wen_d1;
    logic             r_C_wen;
    logic [IDX_W-1:0] r_ci_d1;
    logic [IDX_W-1:0] r_cj_d1;
    logic [IDX_W-1:0] r_ci;
    logic [IDX_W-1:0] r_cj;
    logic [CNT_W-1:0] r_cycle_cnt;

    mm_loop_cnt #(
        .DIM   (DIM),
        .IDX_W (IDX_W)
    ) u_loop_cnt (
        .clk      (clk),
        .reset    (reset),
        .en       (w_cnt_en),
        .clr      (w_cnt_clr),
        .i        (w_i),
        .j        (w_j),
        .k        (w_k),
        .k_last   (w_k_last),
        .all_last (w_all_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start && !load_mem) w_state_nxt = RUN;
            end
            RUN: begin
                if (load_mem)        w_state_nxt = IDLE;
                else if (w_all_last) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (load_mem)          w_state_nxt = IDLE;
                else if (r_drain == '0) w_state_nxt = DONE;
            end
            DONE: begin
                if (load_mem)   w_state_nxt = IDLE;
                else if (start) w_state_nxt = RUN;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_issue     = (r_state == RUN);
    assign w_active    = (r_state == RUN) || (r_state == DRAIN);
    assign w_abort_req = w_active && load_mem;
    assign w_job_start = (w_state_nxt == RUN) && (r_state != RUN);

    // Indices freeze on the last issue point so they hold through DRAIN and DONE.
    assign w_cnt_en  = w_issue && !w_all_last;
    assign w_cnt_clr = (w_state_nxt == IDLE) || w_job_start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drain <= '0;
        end else if (w_issue && (w_state_nxt == DRAIN)) begin
            r_drain <= DRAIN_LOAD;
        end else if ((r_state == DRAIN) && (r_drain != '0)) begin
            r_drain <= r_drain - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_busy  <= (w_state_nxt == RUN) || (w_state_nxt == DRAIN);
            r_done  <= (w_state_nxt == DONE);
            r_abort <= w_abort_req;
        end
    end

    // mac_clr trails the k==0 issue by the read latency; C_wen trails k==DIM-1 by read+MAC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mac_clr <= 1'b0;
            r_wen_d1  <= 1'b0;
            r_C_wen   <= 1'b0;
            r_ci_d1   <= '0;
            r_cj_d1   <= '0;
            r_ci      <= '0;
            r_cj      <= '0;
        end else if (w_abort_req) begin
            r_mac_clr <= 1'b0;
            r_wen_d1  <= 1'b0;
            r_C_wen   <= 1'b0;
            r_ci_d1   <= '0;
            r_cj_d1   <= '0;
            r_ci      <= '0;
            r_cj      <= '0;
        end else begin
            r_mac_clr <= w_issue && (w_k == '0);
            r_wen_d1  <= w_issue && w_k_last;
            r_C_wen   <= r_wen_d1;
            r_ci_d1   <= w_i;
            r_cj_d1   <= w_j;
            r_ci      <= r_ci_d1;
            r_cj      <= r_cj_d1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle_cnt <= '0;
        end else if (w_job_start) begin
            r_cycle_cnt <= '0;
        end else if (w_active && (r_cycle_cnt != '1)) begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign abort     = r_abort;
    assign mac_clr   = r_mac_clr;
    assign C_wen     = r_C_wen;
    assign Ai        = w_i;
    assign Aj        = w_k;
    assign Bi        = w_k;
    assign Bj        = w_j;
    assign Ci        = r_ci;
    assign Cj        = r_cj;
    assign cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_mm_job_ctrl.sv
// Bench for mm_job_ctrl: per-cycle timing model built from the job-cycle formulas,
// plus a RAM/MAC datapath model whose C result is compared with the matrix product.
module tb_mm_job_ctrl;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int CW = 16;
    localparam int N3 = N * N * N;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          load_mem;
    logic          busy, done, abort, mac_clr, C_wen;
    logic [IW-1:0] Ai, Aj, Bi, Bj, Ci, Cj;
    logic [CW-1:0] cycle_cnt;

    always #5 clk = ~clk;

    mm_job_ctrl #(
        .DIM   (N),
        .IDX_W (IW),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .load_mem  (load_mem),
        .busy      (busy),
        .done      (done),
        .abort     (abort),
        .mac_clr   (mac_clr),
        .C_wen     (C_wen),
        .Ai        (Ai),
        .Aj        (Aj),
        .Bi        (Bi),
        .Bj        (Bj),
        .Ci        (Ci),
        .Cj        (Cj),
        .cycle_cnt (cycle_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // model: mode 0 idle, 1 job (cycle m_t), 2 done
    int m_mode, m_t, m_cnt;
    bit m_abort;

    int mem_a [N][N];
    int mem_b [N][N];
    int mem_c [N][N];
    int rd_a, rd_b, acc;
    int mem_pat;

    int c_ai, c_aj, c_bi, c_bj, c_ci, c_cj;
    bit c_clr, c_wen;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sample();
        c_ai  = int'(Ai);  c_aj = int'(Aj);
        c_bi  = int'(Bi);  c_bj = int'(Bj);
        c_ci  = int'(Ci);  c_cj = int'(Cj);
        c_clr = mac_clr;   c_wen = C_wen;
    endtask

    task automatic load_pattern();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                case (mem_pat)
                    1:       begin mem_a[r][c] = (r == c) ? 1 : 0; mem_b[r][c] = 3; end
                    2:       begin mem_a[r][c] = 1; mem_b[r][c] = 1; end
                    default: begin mem_a[r][c] = int'($urandom_range(0, 15));
                                   mem_b[r][c] = int'($urandom_range(0, 15)); end
                endcase
                mem_c[r][c] = -1;
            end
        end
    endtask

    task automatic check_outputs();
        int e_busy, e_done, e_abort, e_clr, e_wen, e_cnt, e_i, e_j, e_k, e;
        e_busy = 0; e_done = 0; e_abort = 0; e_clr = 0; e_wen = 0;
        e_cnt = m_cnt; e_i = 0; e_j = 0; e_k = 0; e = 0;
        case (m_mode)
            0: e_abort = int'(m_abort);
            1: begin
                e_busy = 1;
                e_cnt  = m_t;
                if (m_t < N3) begin
                    e_i = m_t / (N * N);
                    e_j = (m_t / N) % N;
                    e_k = m_t % N;
                end else begin
                    e_i = N - 1; e_j = N - 1; e_k = N - 1;
                end
                e_clr = (m_t >= 1 && m_t <= N3 - N + 1 && (m_t - 1) % N == 0) ? 1 : 0;
                e_wen = (m_t >= N + 1 && m_t <= N3 + 1 && (m_t - N - 1) % N == 0) ? 1 : 0;
                e = (m_t - N - 1) / N;
            end
            default: begin
                e_done = 1;
                e_i = N - 1; e_j = N - 1; e_k = N - 1;
            end
        endcase
        check_eq("busy", busy, e_busy);
        check_eq("done", done, e_done);
        check_eq("abort", abort, e_abort);
        check_eq("mac_clr", mac_clr, e_clr);
        check_eq("C_wen", C_wen, e_wen);
        check_eq("cycle_cnt", cycle_cnt, e_cnt);
        check_eq("Ai", Ai, e_i);
        check_eq("Aj", Aj, e_k);
        check_eq("Bi", Bi, e_k);
        check_eq("Bj", Bj, e_j);
        if (e_wen == 1) begin
            check_eq("Ci", Ci, e / N);
            check_eq("Cj", Cj, e % N);
        end
    endtask

    task automatic check_c();
        int sum;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                sum = 0;
                for (int kk = 0; kk < N; kk++) sum += mem_a[r][kk] * mem_b[kk][c];
                check_eq("c_elem", mem_c[r][c], sum);
            end
        end
    endtask

    task automatic step(input bit s, input bit l);
        bit do_c;
        do_c = 1'b0;
        if (s && !l && m_mode != 1) load_pattern();
        start    = s;
        load_mem = l;
        @(posedge clk);
        if (c_wen) mem_c[c_ci][c_cj] = acc;
        acc  = c_clr ? rd_a * rd_b : acc + rd_a * rd_b;
        rd_a = mem_a[c_ai][c_aj];
        rd_b = mem_b[c_bi][c_bj];
        m_abort = 1'b0;
        case (m_mode)
            0: if (s && !l) begin m_mode = 1; m_t = 0; m_cnt = 0; end
            1: begin
                if (l) begin
                    m_mode = 0; m_abort = 1'b1; m_cnt = m_t + 1;
                end else begin
                    m_t++;
                    if (m_t == N3 + 2) begin m_mode = 2; m_cnt = m_t; do_c = 1'b1; end
                end
            end
            default: begin
                if (l)      m_mode = 0;
                else if (s) begin m_mode = 1; m_t = 0; m_cnt = 0; end
            end
        endcase
        @(negedge clk);
        check_outputs();
        if (do_c) check_c();
        sample();
    endtask

    task automatic run_to_done();
        int n;
        n = 0;
        while (m_mode != 2 && n < 200) begin
            step(1'b0, 1'b0);
            n++;
        end
        check_eq("done_reached", done, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; start = 1'b0; load_mem = 1'b0;
        m_mode = 0; m_t = 0; m_cnt = 0; m_abort = 1'b0;
        rd_a = 0; rd_b = 0; acc = 0; mem_pat = 0;
        load_pattern();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check_outputs();
        check_eq("rst_Ci", Ci, 0);
        check_eq("rst_Cj", Cj, 0);
        sample();

        // start while host owns memories, then A=I, B=3s
        mem_pat = 1;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        run_to_done();
        repeat (3) step(1'b0, 1'b0);

        // A=B=all ones, then host takes memories back
        mem_pat = 2;
        step(1'b1, 1'b0);
        run_to_done();
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);

        // abort in RUN cycle 30
        mem_pat = 0;
        step(1'b1, 1'b0);
        while (m_mode == 1 && m_t < 30) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0);

        // back-to-back jobs with start held high
        for (int n = 0; n < 2 * (N3 + 3) + 5; n++) step(1'b1, 1'b0);
        run_to_done();
        repeat (2) step(1'b0, 1'b0);

        // asynchronous reset in RUN cycle 20
        step(1'b1, 1'b0);
        while (m_mode == 1 && m_t < 20) step(1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_mac_clr", mac_clr, 0);
        check_eq("arst_C_wen", C_wen, 0);
        check_eq("arst_Ai", Ai, 0);
        check_eq("arst_Aj", Aj, 0);
        check_eq("arst_Bj", Bj, 0);
        check_eq("arst_Ci", Ci, 0);
        check_eq("arst_Cj", Cj, 0);
        check_eq("arst_cnt", cycle_cnt, 0);
        m_mode = 0; m_cnt = 0; m_abort = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        check_outputs();
        sample();
        repeat (6) step(1'b0, 1'b0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit s, l;
            s = ($urandom_range(0, 99) < 30);
            l = ($urandom_range(0, 199) == 0) || (m_mode != 1 && $urandom_range(0, 7) == 0);
            step(s, l);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
